// File: rtl/jk_flip_flop.sv
// jk_flip_flop: vector of independent edge-triggered JK cells with async active-high reset
module jk_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    always_comb begin
        q_d = q_q;
        for (int n = 0; n < WIDTH; n++) begin
            case ({j[n], k[n]})
                2'b00:   q_d[n] = q_q[n];
                2'b01:   q_d[n] = 1'b0;
                2'b10:   q_d[n] = 1'b1;
                default: q_d[n] = ~q_q[n];
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RESET_VALUE;
        else     q_q <= q_d;
    end
    assign q  = q_q;
    assign qn = ~q_q;
endmodule

// File: tb/tb_jk_flip_flop.sv
// tb_jk_flip_flop: directed checks of a 1-bit cell and a 4-bit cell with non-zero reset value
module tb_jk_flip_flop;
    logic       clk = 1'b0;
    logic       rst;
    logic       j, k, q, qn;
    logic [3:0] jw, kw, qw, qnw;
    int         n_chk  = 0;
    int         n_fail = 0;

    jk_flip_flop dut (
        .j(j), .k(k), .clk(clk), .rst(rst), .q(q), .qn(qn)
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut_w (
        .j(jw), .k(kw), .clk(clk), .rst(rst), .q(qw), .qn(qnw)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; j = 1'b0; k = 1'b0; jw = 4'b0000; kw = 4'b0000;
        #1;
        check("reset_q", {3'b0, q}, 4'd0);
        check("reset_qn", {3'b0, qn}, 4'd1);
        check("reset_qw", qw, 4'b1010);
        check("reset_qnw", qnw, 4'b0101);
        #10;
        check("reset_across_edge", {3'b0, q}, 4'd0);
        #9 rst = 1'b0;
        #11;
        check("hold", {3'b0, q}, 4'd0);
        check("hold_w", qw, 4'b1010);
        #4 j = 1'b0; k = 1'b1; jw = 4'b1100; kw = 4'b1010;
        #16;
        check("reset_mode", {3'b0, q}, 4'd0);
        check("mixed_w", qw, 4'b0100);
        #4 j = 1'b1; k = 1'b0; jw = 4'b1111; kw = 4'b1111;
        #16;
        check("set_mode", {3'b0, q}, 4'd1);
        check("set_qn", {3'b0, qn}, 4'd0);
        check("toggle_w", qw, 4'b1011);
        check("toggle_qnw", qnw, 4'b0100);
        #4 j = 1'b1; k = 1'b1; jw = 4'b0000; kw = 4'b1001;
        #16;
        check("toggle_1", {3'b0, q}, 4'd0);
        check("reset_bits_w", qw, 4'b0010);
        #20;
        check("toggle_2", {3'b0, q}, 4'd1);
        #20;
        check("toggle_3", {3'b0, q}, 4'd0);
        #20;
        check("toggle_4", {3'b0, q}, 4'd1);
        #4 rst = 1'b1;
        #1;
        check("async_rst_q", {3'b0, q}, 4'd0);
        check("async_rst_qn", {3'b0, qn}, 4'd1);
        check("async_rst_qw", qw, 4'b1010);
        j = 1'b1; k = 1'b0;
        #15;
        check("rst_dominates_edge", {3'b0, q}, 4'd0);
        check("rst_dominates_w", qw, 4'b1010);
        #4 rst = 1'b0; j = 1'b0; k = 1'b0;
        #5 j = 1'b1;
        #5 j = 1'b0;
        #6;
        check("inter_edge_pulse", {3'b0, q}, 4'd0);
        #4 j = 1'b1; k = 1'b0;
        #16;
        check("set_after_rst", {3'b0, q}, 4'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
